header_pad: RTL and testbench

Upstream stage of the double-SHA-256 hasher. It accepts an 80-byte Bitcoin block header as a byte stream and assembles it into the 1024-bit, two-block padded SHA-256 message that the hasher consumes on its `message` input. Optionally, it then sweeps the nonce field, presenting one new message per consumer handshake until the nonce space wraps or the header is flushed.

---
 rtl/header_pad.sv | 117 +++++++++++
 tb/tb_header_pad.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/header_pad.sv
// Assembles an 80-byte block header into the 1024-bit padded double-SHA message.
// Define HEADER_PAD_NONCE_SWEEP_EN to add the nonce sweep (STEP state, nonce_wrap).
module header_pad #(
  parameter logic [31:0] NONCE_STEP = 32'd1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_byte,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic [1023:0] message,
  output logic          msg_valid,
  input  logic          msg_ready,
  output logic [31:0]   nonce,
  output logic          nonce_wrap,
  output logic          busy
);

  typedef enum logic [1:0] {LOAD, OFFER, STEP} state_t;

  state_t       state;
  logic [6:0]   count;
  logic [631:0] hdr_buf;
  logic         accept_byte;
  logic         accept_msg;

  // A step of zero would never terminate; above 2^31 the sweep skips most of the space.
  if (NONCE_STEP == 32'd0 || NONCE_STEP > 32'h8000_0000) begin : g_step_check
    $error("header_pad: NONCE_STEP must be in 1..2^31");
  end

  assign in_ready    = (state == LOAD) & ~flush;
  assign busy        = (state != LOAD);
  assign accept_byte = in_valid & in_ready;
  assign accept_msg  = msg_valid & msg_ready;

`ifdef HEADER_PAD_NONCE_SWEEP_EN
  logic [32:0] step_sum;
  logic        wrap_q;

  assign step_sum   = {1'b0, nonce} + {1'b0, NONCE_STEP};
  assign nonce_wrap = wrap_q;
`else
  assign nonce_wrap = 1'b0;
`endif

  // Bytes 0..78 wait in hdr_buf; byte 79 arrives straight from the input when the message is built.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      count     <= 7'd0;
      hdr_buf   <= '0;
      message   <= '0;
      nonce     <= 32'd0;
      msg_valid <= 1'b0;
`ifdef HEADER_PAD_NONCE_SWEEP_EN
      wrap_q    <= 1'b0;
`endif
    end else if (flush) begin
      state     <= LOAD;
      count     <= 7'd0;
      msg_valid <= 1'b0;
`ifdef HEADER_PAD_NONCE_SWEEP_EN
      wrap_q    <= 1'b0;
`endif
    end else begin
`ifdef HEADER_PAD_NONCE_SWEEP_EN
      wrap_q <= 1'b0;
`endif
      case (state)
        LOAD: begin
          if (accept_byte) begin
            if (count == 7'd79) begin
              message   <= {hdr_buf, in_byte, 8'h80, 312'd0, 64'h0000_0000_0000_0280};
              nonce     <= {in_byte, hdr_buf[7:0], hdr_buf[15:8], hdr_buf[23:16]};
              msg_valid <= 1'b1;
              count     <= 7'd0;
              state     <= OFFER;
            end else begin
              for (int i = 0; i < 79; i++) begin
                if (count == 7'(i)) hdr_buf[631-8*i -: 8] <= in_byte;
              end
              count <= count + 7'd1;
            end
          end
        end
        OFFER: begin
          if (accept_msg) begin
            msg_valid <= 1'b0;
`ifdef HEADER_PAD_NONCE_SWEEP_EN
            // The overflow is known at accept time so the pulse lines up with STEP.
            wrap_q <= step_sum[32];
            state  <= STEP;
`else
            state  <= LOAD;
`endif
          end
        end
`ifdef HEADER_PAD_NONCE_SWEEP_EN
        STEP: begin
          if (step_sum[32]) begin
            state <= LOAD;
          end else begin
            message[415:384] <= {step_sum[7:0], step_sum[15:8], step_sum[23:16], step_sum[31:24]};
            nonce            <= step_sum[31:0];
            msg_valid        <= 1'b1;
            state            <= OFFER;
          end
        end
`endif
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_header_pad.sv
// Self-checking bench for header_pad: byte-level message model plus directed vectors.
// Follows HEADER_PAD_NONCE_SWEEP_EN the same way the design does.
module tb_header_pad;

  localparam logic [31:0] STEP = 32'd1;
`ifdef HEADER_PAD_NONCE_SWEEP_EN
  localparam bit SWEEP = 1'b1;
`else
  localparam bit SWEEP = 1'b0;
`endif
  localparam int P_LOAD  = 0;
  localparam int P_OFFER = 1;
  localparam int P_STEP  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_byte = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic [1023:0] message;
  logic          msg_valid;
  logic          msg_ready = 1'b0;
  logic [31:0]   nonce;
  logic          nonce_wrap;
  logic          busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  header_pad #(.NONCE_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .message(message), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .nonce(nonce), .nonce_wrap(nonce_wrap), .busy(busy)
  );

  // Model: the message as 128 plain bytes, the nonce as an integer.
  int          m_phase;
  int          m_cnt;
  logic [7:0]  m_part[80];
  logic [7:0]  m_msg[128];
  logic [31:0] m_nonce;
  logic        m_valid;
  logic        m_wrap;
  longint      m_sum;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_LOAD;
      m_cnt   = 0;
      m_nonce = 32'd0;
      m_valid = 1'b0;
      m_wrap  = 1'b0;
      for (int k = 0; k < 128; k++) m_msg[k] = 8'd0;
    end else begin
      m_sum = longint'(m_nonce) + longint'(STEP);
      if (flush) begin
        m_phase = P_LOAD;
        m_cnt   = 0;
        m_valid = 1'b0;
        m_wrap  = 1'b0;
      end else begin
        case (m_phase)
          P_LOAD: begin
            m_wrap = 1'b0;
            if (in_valid) begin
              m_part[m_cnt] = in_byte;
              if (m_cnt == 79) begin
                for (int k = 0; k < 80; k++) m_msg[k] = m_part[k];
                m_msg[80] = 8'h80;
                for (int k = 81; k < 120; k++) m_msg[k] = 8'h00;
                for (int k = 0; k < 8; k++) m_msg[120+k] = 8'(longint'(640) >> (8*(7-k)));
                m_nonce = {m_part[79], m_part[78], m_part[77], m_part[76]};
                m_valid = 1'b1;
                m_cnt   = 0;
                m_phase = P_OFFER;
              end else begin
                m_cnt = m_cnt + 1;
              end
            end
          end
          P_OFFER: begin
            m_wrap = 1'b0;
            if (msg_ready) begin
              m_valid = 1'b0;
              if (SWEEP) begin
                m_phase = P_STEP;
                m_wrap  = ((m_sum >> 32) != 0);
              end else begin
                m_phase = P_LOAD;
              end
            end
          end
          default: begin
            if (m_wrap) begin
              m_phase = P_LOAD;
            end else begin
              m_nonce   = 32'(m_sum);
              m_msg[76] = m_nonce[7:0];
              m_msg[77] = m_nonce[15:8];
              m_msg[78] = m_nonce[23:16];
              m_msg[79] = m_nonce[31:24];
              m_valid   = 1'b1;
              m_phase   = P_OFFER;
            end
            m_wrap = 1'b0;
          end
        endcase
      end
    end
  end

  function automatic logic [1023:0] modelMessage();
    logic [1023:0] v;
    for (int k = 0; k < 128; k++) v[1023-8*k -: 8] = m_msg[k];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkMessage(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    int bad;
    compared++;
    if (act !== exp) begin
      mismatched++;
      bad = 0;
      for (int k = 127; k >= 0; k--) if (act[1023-8*k -: 8] !== exp[1023-8*k -: 8]) bad = k;
      $display("[TB] FAIL %s: byte %0d got %h expected %h at %0t", name, bad,
               act[1023-8*bad -: 8], exp[1023-8*bad -: 8], $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("in_ready", 32'(in_ready), 32'((m_phase == P_LOAD) && !flush));
      checkOutput("busy", 32'(busy), 32'(m_phase != P_LOAD));
      checkOutput("msg_valid", 32'(msg_valid), 32'(m_valid));
      checkOutput("nonce_wrap", 32'(nonce_wrap), 32'(m_wrap));
      checkOutput("nonce", nonce, m_nonce);
      checkMessage("message", message, modelMessage());
    end
  end

  logic [7:0] tx[80];

  // Drives one cycle of inputs, then returns them to idle just after the edge.
  task automatic applyStimulus(input logic v, input logic [7:0] b, input logic f, input logic r);
    in_valid  = v;
    in_byte   = b;
    flush     = f;
    msg_ready = r;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_byte   = 8'd0;
    flush     = 1'b0;
    msg_ready = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic sendBytes(input int first, input int last);
    for (int i = first; i <= last; i++) applyStimulus(1'b1, tx[i], 1'b0, 1'b0);
  endtask

  task automatic fillPattern(input int seed, input logic [31:0] n);
    for (int i = 0; i < 76; i++) tx[i] = 8'(seed + 13 * i);
    tx[76] = n[7:0];
    tx[77] = n[15:8];
    tx[78] = n[23:16];
    tx[79] = n[31:24];
  endtask

  logic [639:0] genesis;

  initial begin
    genesis = 640'h01000000_00000000000000000000000000000000000000000000000000000000_00000000_3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_msg_valid", 32'(msg_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_nonce", nonce, 32'd0);
    checkMessage("rst_message", message, '0);
    #2 rst = 1'b0;
    #1 checkOutput("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Genesis header with a long idle gap in the middle.
    for (int k = 0; k < 80; k++) tx[k] = genesis[639-8*k -: 8];
    sendBytes(0, 29);
    idleCycles(20);
    sendBytes(30, 78);
    checkOutput("no_early_valid", 32'(msg_valid), 32'd0);
    sendBytes(79, 79);
    checkOutput("genesis_valid", 32'(msg_valid), 32'd1);
    checkOutput("genesis_byte0", 32'(message[1023:1016]), 32'h01);
    checkOutput("genesis_byte80", 32'(message[383:376]), 32'h80);
    checkOutput("genesis_pad_zero", 32'(|message[375:64]), 32'd0);
    checkOutput("genesis_len_hi", message[63:32], 32'd0);
    checkOutput("genesis_len_lo", message[31:0], 32'h280);
    checkOutput("genesis_nonce", nonce, 32'h7c2bac1d);
    checkOutput("model_nonce", m_nonce, 32'h7c2bac1d);
    checkOutput("model_byte80", 32'(m_msg[80]), 32'h80);
    checkOutput("model_len126", 32'(m_msg[126]), 32'h02);
    checkOutput("model_len127", 32'(m_msg[127]), 32'h80);

    // Bytes offered while not loading are ignored.
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    checkOutput("offer_hold_valid", 32'(msg_valid), 32'd1);
    checkOutput("offer_hold_nonce", nonce, 32'h7c2bac1d);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    checkOutput("accept_valid_low", 32'(msg_valid), 32'd0);
    checkOutput("accept_busy", 32'(busy), 32'(SWEEP));
    idleCycles(1);
    checkOutput("after_accept_valid", 32'(msg_valid), 32'(SWEEP));
    checkOutput("after_accept_nonce", nonce, SWEEP ? 32'h7c2bac1e : 32'h7c2bac1d);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

    // msg_ready without a message does nothing.
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    checkOutput("stray_ready_valid", 32'(msg_valid), 32'd0);
    checkOutput("stray_ready_busy", 32'(busy), 32'd0);

    // Sweep from nonce 5.
    fillPattern(5, 32'd5);
    sendBytes(0, 79);
    checkOutput("sweep_base_nonce", nonce, 32'd5);
    checkOutput("model_sweep_base", m_nonce, 32'd5);
    for (int j = 1; j <= 3; j++) begin
      applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
      checkOutput("sweep_gap_valid", 32'(msg_valid), 32'd0);
      idleCycles(1);
      checkOutput("sweep_valid", 32'(msg_valid), 32'(SWEEP));
      checkOutput("sweep_nonce", nonce, SWEEP ? 32'(5 + j) : 32'd5);
      if (j == 1) checkOutput("sweep_bytes76_79", message[415:384], SWEEP ? 32'h06000000 : 32'h05000000);
    end
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

    // Nonce at the top of its range.
    fillPattern(9, 32'hffffffff);
    sendBytes(0, 79);
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b1);
    checkOutput("wrap_pulse", 32'(nonce_wrap), 32'(SWEEP));
    checkOutput("wrap_valid", 32'(msg_valid), 32'd0);
    idleCycles(1);
    checkOutput("wrap_in_ready", 32'(in_ready), 32'd1);
    checkOutput("wrap_pulse_end", 32'(nonce_wrap), 32'd0);
    checkOutput("wrap_valid_after", 32'(msg_valid), 32'd0);
    checkOutput("wrap_nonce_kept", nonce, 32'hffffffff);

    // Flush on byte 40, then a different full header.
    fillPattern(21, 32'h11223344);
    sendBytes(0, 39);
    applyStimulus(1'b1, tx[40], 1'b1, 1'b0);
    checkOutput("flush40_valid", 32'(msg_valid), 32'd0);
    fillPattern(33, 32'ha5a50001);
    sendBytes(0, 79);
    checkOutput("reload_valid", 32'(msg_valid), 32'd1);
    checkOutput("reload_byte0", 32'(message[1023:1016]), 32'(tx[0]));
    checkOutput("reload_byte40", 32'(message[703:696]), 32'(tx[40]));
    checkOutput("reload_nonce", nonce, 32'ha5a50001);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0);

    // Flush together with byte 79 drops it and restarts the count.
    fillPattern(47, 32'hdeadbeef);
    sendBytes(0, 78);
    applyStimulus(1'b1, tx[79], 1'b1, 1'b0);
    checkOutput("flush79_valid", 32'(msg_valid), 32'd0);
    checkOutput("flush79_nonce_kept", nonce, 32'ha5a50001);
    fillPattern(59, 32'h0badf00d);
    sendBytes(0, 79);
    checkOutput("after_flush79_valid", 32'(msg_valid), 32'd1);
    checkOutput("after_flush79_nonce", nonce, 32'h0badf00d);

    // Flush together with msg_ready: no step follows.
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1);
    checkOutput("flush_ready_valid", 32'(msg_valid), 32'd0);
    checkOutput("flush_ready_busy", 32'(busy), 32'd0);
    idleCycles(1);
    checkOutput("flush_ready_nonce", nonce, 32'h0badf00d);
    checkOutput("flush_ready_wrap", 32'(nonce_wrap), 32'd0);

    // Asynchronous reset while offering.
    sendBytes(0, 79);
    checkOutput("pre_rst_valid", 32'(msg_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(msg_valid), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_nonce", nonce, 32'd0);
    checkOutput("async_rst_wrap", 32'(nonce_wrap), 32'd0);
    checkMessage("async_rst_message", message, '0);
    rst = 1'b0;
    #1 checkOutput("async_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    idleCycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
